neighbor_pixel_streamer: RTL and testbench
==========================================

# neighbor_pixel_streamer

Sequential, parametrised generator that takes one event coordinate per request and streams the linear pixel indices of its neighbourhood over a valid/ready interface, one per cycle. The radius and neighbourhood shape are selectable per request. Out-of-sensor neighbours are dropped, and a completion pulse carries the emitted count. It sits between event intake and the graph-build edge search, replacing the fixed, all-at-once neighbour array.

## Interface
- `SENSOR_W`, 120, sensor width in pixels.
- `SENSOR_H`, 100, sensor height in pixels.
- `R_MAX`, 3, maximum supported radius.
- Derived widths:
  - `XW = $clog2(SENSOR_W)`, `YW = $clog2(SENSOR_H)`, `PW = $clog2(SENSOR_W*SENSOR_H)`, `RW = $clog2(R_MAX+1)`, `CW = $clog2((2*R_MAX+1)**2+1)`.
  - `DW = $clog2(R_MAX+1)+1`.

- `clk`  in  1  clock; one clock domain, everything on the rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  high only in IDLE.
- `in_x`  in  XW  event x.
- `in_y`  in  YW  event y.
- `in_radius`  in  RW  radius; values > R_MAX are clamped to R_MAX.
- `in_mode`  in  2  shape: 0 square (Chebyshev), 1 diamond (|dx|+|dy|≤r), 2 disc (dx²+dy²≤r²), 3 treated as square.
- `in_excl_center`  in  1  1 = drop (0,0).
- `out_valid`  out  1  neighbour valid.
- `out_ready`  in  1  consumer ready.
- `out_pixel`  out  PW  neighbour index, (y+dy)*SENSOR_W+(x+dx).
- `out_dx`, `out_dy`  out  DW signed  offset of the emitted neighbour.
- `done`  out  1  one-cycle pulse at end of request.
- `count`  out  CW  neighbours emitted; valid while `done`=1.
- `err`  out  1  pulses with `done` when the input coordinate is out of sensor.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE → SCAN → DRAIN → DONE → IDLE.
- **IDLE:** `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture x, y, clamped r, mode, excl; set cdx=cdy=−r; clear count.
  - If in_x ≥ SENSOR_W or in_y ≥ SENSOR_H, go to DONE with `err` set; else go to SCAN.
- **SCAN:** evaluate one candidate (cdx,cdy) per non-stalled cycle. Scan order is row-major: cdy outer from −r to +r, cdx inner from −r to +r.
  - A candidate is accepted iff all of the following hold:
    - it passes the shape mask;
    - it is not (0,0) when excl is set;
    - 0 ≤ x+cdx < SENSOR_W;
    - 0 ≤ y+cdy < SENSOR_H.
  - Bounds arithmetic is signed, one bit wider than XW/YW plus DW.
  - Disc uses an exact integer compare of squares.
- **Output register:** single entry.
  - An accepted candidate loads it when it is empty or being consumed in the same cycle (`out_valid`&&`out_ready`); count then increments.
  - If an accepted candidate finds the register full and not consumed, the generator stalls and holds cdx/cdy.
  - Rejected candidates never stall and produce no output.
- After candidate (+r,+r) is processed, go to DRAIN.
- **DRAIN:** wait until the output register is empty, then go to DONE.
- **DONE:** one cycle with `done`=1, `count` final, `err` as captured. Next state is IDLE.
- r=0: one candidate (0,0). With excl set, zero outputs and `done` with `count`=0.
- Output stability: `out_pixel`/`out_dx`/`out_dy` stay stable while `out_valid`&&!`out_ready`.
- No drops or duplicates.

## Timing
- Reset (`rstn`=0 at an edge) forces, from the next cycle:
  - state IDLE, `in_ready`=1;
  - `out_valid`=0, `out_pixel`=0, `out_dx`=`out_dy`=0;
  - `done`=0, `err`=0, `count`=0, `busy`=0.
- Reset mid-scan discards the request and any pending output without a `done` pulse.
- Handshake at edge E0 → first candidate evaluated in the cycle after E0. If accepted, `out_valid`=1 from edge E1 (one cycle after the handshake cycle).
- With `out_ready` held 1, throughput is one candidate per cycle. A scan takes (2r+1)² cycles, plus 1 DRAIN cycle when the last output is consumed, plus 1 DONE cycle.
- Invalid coordinate: `done`&&`err` in the cycle after the handshake; no `out_valid`.
- `in_ready` is low from the handshake edge until DONE has completed; the next request can be accepted in the first IDLE cycle.

## Test plan
- (12,25), r=1, square, excl=0, `out_ready`=1 → 2891, 2892, 2893, 3011, 3012, 3013, 3131, 3132, 3133 in order; `done` with `count`=9, `err`=0.
- (119,99), r=1, square, excl=1 → 11878, 11879, 11998; `count`=3.
- (60,50), r=3:
  - square → 49 outputs;
  - diamond → 25 outputs;
  - disc → 29 outputs;
  - mode 3 → 49 outputs;
  - r=2 diamond and r=2 disc → 13 outputs each;
  - r=7 → clamped, 49 outputs (square).
- (120,99) and (119,100) → `done`=1, `err`=1, `count`=0, `out_valid` never high. r=0 with excl=1 at (5,5) → `count`=0, `err`=0.
- (12,25), r=3, square with random 50% `out_ready` → same sequence as with `out_ready`=1 (the in-bounds 3×3..7×7 order), `count`=49, outputs stable under stall, no duplicates.
- `rstn` low one cycle at scan cycle 10 → next cycle `out_valid`=0, `in_ready`=1, no `done` pulse; a following request for (12,25) r=1 reproduces the first scenario exactly.

Source files
------------

// File: rtl/neighbor_pixel_streamer_if.sv
// Request / neighbour-stream bundle for neighbor_pixel_streamer.
//
// Purpose: groups the request handshake (in_*), the neighbour stream
// (out_*) and the per-request status (done/count/err/busy) into one port.
// The master modport is the side that issues requests and consumes
// neighbours. The slave modport is the streamer itself.
//
// Signals:
//   in_valid/in_ready      request handshake
//   in_x, in_y             event coordinate
//   in_radius              radius, clamped to R_MAX inside the streamer
//   in_mode                0 square, 1 diamond, 2 disc, 3 square
//   in_excl_center         drop the (0,0) offset
//   out_valid/out_ready    neighbour handshake
//   out_pixel              linear neighbour index (y+dy)*SENSOR_W+(x+dx)
//   out_dx, out_dy         signed offset of the emitted neighbour
//   done, count, err       end-of-request pulse, emitted count, bad coordinate
//   busy                   streamer not idle
interface neighbor_pixel_streamer_if #(
    parameter int SENSOR_W = 120,
    parameter int SENSOR_H = 100,
    parameter int R_MAX    = 3
) ();
    localparam int XW = $clog2(SENSOR_W);
    localparam int YW = $clog2(SENSOR_H);
    localparam int PW = $clog2(SENSOR_W*SENSOR_H);
    localparam int RW = $clog2(R_MAX+1);
    localparam int CW = $clog2((2*R_MAX+1)**2+1);
    localparam int DW = $clog2(R_MAX+1)+1;

    logic                 in_valid;
    logic                 in_ready;
    logic [XW-1:0]        in_x;
    logic [YW-1:0]        in_y;
    logic [RW-1:0]        in_radius;
    logic [1:0]           in_mode;
    logic                 in_excl_center;
    logic                 out_valid;
    logic                 out_ready;
    logic [PW-1:0]        out_pixel;
    logic signed [DW-1:0] out_dx;
    logic signed [DW-1:0] out_dy;
    logic                 done;
    logic [CW-1:0]        count;
    logic                 err;
    logic                 busy;

    modport master (
        output in_valid, in_x, in_y, in_radius, in_mode, in_excl_center, out_ready,
        input  in_ready, out_valid, out_pixel, out_dx, out_dy, done, count, err, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_radius, in_mode, in_excl_center, out_ready,
        output in_ready, out_valid, out_pixel, out_dx, out_dy, done, count, err, busy
    );
endinterface

// File: rtl/neighbor_pixel_streamer.sv
// neighbor_pixel_streamer
//
// Purpose: takes one event coordinate per request and streams the linear
// pixel indices of its neighbourhood, one candidate per cycle, in row-major
// order. The order is dy from -r to +r on the outside and dx from -r to +r
// on the inside. A candidate is emitted only if it passes the shape mask,
// is not an excluded centre, and lies on the sensor. A single-entry output
// register sits on the stream. The scan stalls only when an accepted
// candidate meets a full register that is not being drained. Each request
// ends with a one-cycle done pulse carrying the emitted count.
//
// Ports:
//   clk   rising-edge clock
//   rstn  synchronous active-low reset
//   bus   neighbor_pixel_streamer_if.slave (request, stream, status)
//
// States:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | in_ready=1; waits for a request and captures it
//   S_SCAN  | evaluates candidate (cdx,cdy); advances unless stalled
//   S_DRAIN | all candidates done; waits for the output register to empty
//   S_DONE  | one cycle of done=1 with final count and err
module neighbor_pixel_streamer #(
    parameter int SENSOR_W = 120,
    parameter int SENSOR_H = 100,
    parameter int R_MAX    = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    neighbor_pixel_streamer_if.slave bus
);
    localparam int XW  = $clog2(SENSOR_W);
    localparam int YW  = $clog2(SENSOR_H);
    localparam int PW  = $clog2(SENSOR_W*SENSOR_H);
    localparam int RW  = $clog2(R_MAX+1);
    localparam int CW  = $clog2((2*R_MAX+1)**2+1);
    localparam int DW  = $clog2(R_MAX+1)+1;
    localparam int SXW = XW + DW + 1;
    localparam int SYW = YW + DW + 1;
    localparam int SQW = 2*DW + 1;

    localparam logic signed [SXW-1:0] SX_LIM = SXW'(SENSOR_W);
    localparam logic signed [SYW-1:0] SY_LIM = SYW'(SENSOR_H);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic [RW-1:0]        r_r;
    logic [1:0]           r_mode;
    logic                 r_excl;
    logic signed [DW-1:0] r_cdx;
    logic signed [DW-1:0] r_cdy;
    logic [CW-1:0]        r_count;
    logic                 r_done;
    logic                 r_err;
    logic                 r_out_valid;
    logic [PW-1:0]        r_out_pixel;
    logic signed [DW-1:0] r_out_dx;
    logic signed [DW-1:0] r_out_dy;

    logic [RW-1:0]         w_rclamp;
    logic                  w_in_bad;
    logic [DW-1:0]         w_adx;
    logic [DW-1:0]         w_ady;
    logic [DW:0]           w_man;
    logic [DW:0]           w_rext;
    logic [SQW-1:0]        w_dsq;
    logic [SQW-1:0]        w_rsq;
    logic signed [DW-1:0]  w_rpos;
    logic signed [SXW-1:0] w_sx;
    logic signed [SYW-1:0] w_sy;
    logic                  w_shape;
    logic                  w_center;
    logic                  w_inb;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_load;
    logic                  w_stall;
    logic [PW-1:0]         w_pix;

    always_comb begin
        w_rclamp = (bus.in_radius > RW'(R_MAX)) ? RW'(R_MAX) : bus.in_radius;
        // Compare one bit wider so a power-of-two sensor size does not wrap the limit to 0.
        w_in_bad = ((XW+1)'(bus.in_x) >= (XW+1)'(SENSOR_W)) ||
                   ((YW+1)'(bus.in_y) >= (YW+1)'(SENSOR_H));

        w_adx  = r_cdx[DW-1] ? DW'(-r_cdx) : DW'(r_cdx);
        w_ady  = r_cdy[DW-1] ? DW'(-r_cdy) : DW'(r_cdy);
        w_man  = (DW+1)'(w_adx) + (DW+1)'(w_ady);
        w_rext = (DW+1)'(r_r);
        w_dsq  = SQW'(w_adx) * SQW'(w_adx) + SQW'(w_ady) * SQW'(w_ady);
        w_rsq  = SQW'(r_r) * SQW'(r_r);
        w_rpos = DW'(r_r);

        // Neighbour coordinate in signed arithmetic so that x-1 at x=0 goes negative.
        w_sx = SXW'($signed({1'b0, r_x})) + SXW'(r_cdx);
        w_sy = SYW'($signed({1'b0, r_y})) + SYW'(r_cdy);

        unique case (r_mode)
            2'd1:    w_shape = (w_man <= w_rext);
            2'd2:    w_shape = (w_dsq <= w_rsq);
            default: w_shape = 1'b1;
        endcase

        w_center = (r_cdx == '0) && (r_cdy == '0);
        w_inb    = !w_sx[SXW-1] && (w_sx < SX_LIM) &&
                   !w_sy[SYW-1] && (w_sy < SY_LIM);
        w_accept = w_shape && !(r_excl && w_center) && w_inb;
        w_last   = (r_cdx == w_rpos) && (r_cdy == w_rpos);

        w_load  = (r_state == S_SCAN) && w_accept && (!r_out_valid || bus.out_ready);
        w_stall = (r_state == S_SCAN) && w_accept && r_out_valid && !bus.out_ready;

        w_pix = PW'(w_sy[YW-1:0]) * PW'(SENSOR_W) + PW'(w_sx[XW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_r         <= '0;
            r_mode      <= '0;
            r_excl      <= 1'b0;
            r_cdx       <= '0;
            r_cdy       <= '0;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_dx    <= '0;
            r_out_dy    <= '0;
        end else begin
            r_done <= 1'b0;

            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            // A load in the same cycle as a consume overrides the clear above.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_pixel <= w_pix;
                r_out_dx    <= r_cdx;
                r_out_dy    <= r_cdy;
                r_count     <= r_count + 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_x     <= bus.in_x;
                        r_y     <= bus.in_y;
                        r_r     <= w_rclamp;
                        r_mode  <= bus.in_mode;
                        r_excl  <= bus.in_excl_center;
                        r_cdx   <= -$signed(DW'(w_rclamp));
                        r_cdy   <= -$signed(DW'(w_rclamp));
                        r_count <= '0;
                        if (w_in_bad) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (!w_stall) begin
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end else if (r_cdx == w_rpos) begin
                            r_cdx <= -w_rpos;
                            r_cdy <= r_cdy + DW'(1);
                        end else begin
                            r_cdx <= r_cdx + DW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_out_valid || bus.out_ready) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_pixel = r_out_pixel;
    assign bus.out_dx    = r_out_dx;
    assign bus.out_dy    = r_out_dy;
    assign bus.done      = r_done;
    assign bus.count     = r_count;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_neighbor_pixel_streamer.sv
// Self-checking bench for neighbor_pixel_streamer: a neighbourhood model
// built from plain loops over (dx,dy), one compare process on the falling
// edge, directed scenarios with literal expectations, then random requests.
module tb_neighbor_pixel_streamer;
    localparam int SENSOR_W = 120;
    localparam int SENSOR_H = 100;
    localparam int R_MAX    = 3;
    localparam int XW = $clog2(SENSOR_W);
    localparam int YW = $clog2(SENSOR_H);
    localparam int RW = $clog2(R_MAX+1);

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    neighbor_pixel_streamer_if #(.SENSOR_W(SENSOR_W), .SENSOR_H(SENSOR_H), .R_MAX(R_MAX)) bus ();

    neighbor_pixel_streamer #(.SENSOR_W(SENSOR_W), .SENSOR_H(SENSOR_H), .R_MAX(R_MAX)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        int pix;
        int dx;
        int dy;
    } nb_t;

    nb_t exp_q[$];
    nb_t e_cur;
    int  got_pix[$];
    int  lit[$];
    int  exp_count = 0;
    int  exp_err   = 0;
    int  n_done    = 0;
    int  n_cmp     = 0;
    int  n_fail    = 0;
    bit  rand_rdy  = 1'b0;
    bit  prev_stall = 1'b0;
    int  prev_pix, prev_dx, prev_dy;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Neighbourhood straight from the shape / exclusion / bounds rules.
    function automatic void model(input int x, input int y, input int r_in, input int mode,
                                  input int excl, output int cnt, output int err);
        int r;
        bit ok;
        r   = (r_in > R_MAX) ? R_MAX : r_in;
        cnt = 0;
        err = 0;
        if (x >= SENSOR_W || y >= SENSOR_H) begin
            err = 1;
            return;
        end
        for (int dy = -r; dy <= r; dy++) begin
            for (int dx = -r; dx <= r; dx++) begin
                if (mode == 1)      ok = ((dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy)) <= r;
                else if (mode == 2) ok = (dx*dx + dy*dy) <= r*r;
                else                ok = 1'b1;
                if (excl != 0 && dx == 0 && dy == 0) ok = 1'b0;
                if (x+dx < 0 || x+dx >= SENSOR_W || y+dy < 0 || y+dy >= SENSOR_H) ok = 1'b0;
                if (ok) begin
                    exp_q.push_back('{pix: (y+dy)*SENSOR_W + (x+dx), dx: dx, dy: dy});
                    cnt++;
                end
            end
        end
    endfunction

    // Compare process: stream content, stall stability, done status.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(bus.out_valid), 1);
                check("stall_pixel", int'(bus.out_pixel), prev_pix);
                check("stall_dx", int'($signed(bus.out_dx)), prev_dx);
                check("stall_dy", int'($signed(bus.out_dy)), prev_dy);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_out", int'(bus.out_valid), 0);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("out_pixel", int'(bus.out_pixel), e_cur.pix);
                    check("out_dx", int'($signed(bus.out_dx)), e_cur.dx);
                    check("out_dy", int'($signed(bus.out_dy)), e_cur.dy);
                    got_pix.push_back(int'(bus.out_pixel));
                end
            end
            if (bus.done) begin
                check("done_count", int'(bus.count), exp_count);
                check("done_err", int'(bus.err), exp_err);
                check("done_leftover", exp_q.size(), 0);
                n_done++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_pix   = int'(bus.out_pixel);
            prev_dx    = int'($signed(bus.out_dx));
            prev_dy    = int'($signed(bus.out_dy));
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic issue(input int x, input int y, input int r, input int mode, input int excl);
        int k;
        k = 0;
        @(posedge clk);
        #1;
        while (!bus.in_ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("in_ready_before_req", int'(bus.in_ready), 1);
        bus.in_x           = XW'(x);
        bus.in_y           = YW'(y);
        bus.in_radius      = RW'(r);
        bus.in_mode        = 2'(mode);
        bus.in_excl_center = 1'(excl);
        bus.in_valid       = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // lat: 1 = check done in the cycle after handshake, 2 = check first output one cycle later
    task automatic req(input int x, input int y, input int r, input int mode, input int excl,
                       input int lit_cnt, input int lat);
        int start;
        int k;
        model(x, y, r, mode, excl, exp_count, exp_err);
        if (lit_cnt >= 0) check("model_count", exp_count, lit_cnt);
        got_pix.delete();
        start = n_done;
        issue(x, y, r, mode, excl);
        if (lat == 1) begin
            @(negedge clk);
            check("err_latency_done", int'(bus.done), 1);
        end else if (lat == 2) begin
            @(negedge clk);
            check("first_latency_early", int'(bus.out_valid), 0);
            @(negedge clk);
            check("first_latency", int'(bus.out_valid), 1);
        end
        for (k = 0; k < 600; k++) begin
            if (n_done != start) break;
            @(negedge clk);
            #1;
        end
        check("done_seen", n_done - start, 1);
        @(posedge clk);
        #1;
        check("ready_after_done", int'(bus.in_ready), 1);
        check("busy_after_done", int'(bus.busy), 0);
    endtask

    task automatic check_seq(input string name);
        check({name, "_len"}, got_pix.size(), lit.size());
        for (int i = 0; i < lit.size(); i++) begin
            if (i < got_pix.size()) check(name, got_pix[i], lit[i]);
        end
    endtask

    initial begin
        int start;
        int rx, ry;
        rstn               = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_x           = '0;
        bus.in_y           = '0;
        bus.in_radius      = '0;
        bus.in_mode        = '0;
        bus.in_excl_center = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_pixel", int'(bus.out_pixel), 0);
        check("rst_out_dx", int'($signed(bus.out_dx)), 0);
        check("rst_out_dy", int'($signed(bus.out_dy)), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_count", int'(bus.count), 0);
        check("rst_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        req(12, 25, 1, 0, 0, 9, 2);
        lit = '{2891, 2892, 2893, 3011, 3012, 3013, 3131, 3132, 3133};
        check_seq("seq_12_25");

        req(119, 99, 1, 0, 1, 3, 0);
        lit = '{11878, 11879, 11998};
        check_seq("seq_119_99");

        req(60, 50, 3, 0, 0, 49, 0);
        req(60, 50, 3, 1, 0, 25, 0);
        req(60, 50, 3, 2, 0, 29, 0);
        req(60, 50, 3, 3, 0, 49, 0);
        req(60, 50, 2, 1, 0, 13, 0);
        req(60, 50, 2, 2, 0, 13, 0);

        req(120, 99, 1, 0, 0, 0, 1);
        req(119, 100, 1, 0, 0, 0, 1);
        req(5, 5, 0, 0, 1, 0, 0);
        req(5, 5, 0, 0, 0, 1, 2);

        rand_rdy = 1'b1;
        req(12, 25, 3, 0, 0, 49, 0);
        rand_rdy = 1'b0;

        // Reset in the middle of a scan: no done pulse, clean restart.
        model(60, 50, 3, 0, 0, exp_count, exp_err);
        start = n_done;
        issue(60, 50, 3, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        repeat (5) @(negedge clk);
        check("midrst_no_done", n_done - start, 0);

        req(12, 25, 1, 0, 0, 9, 2);
        lit = '{2891, 2892, 2893, 3011, 3012, 3013, 3131, 3132, 3133};
        check_seq("seq_after_rst");

        for (int n = 0; n < 30; n++) begin
            rand_rdy = 1'($urandom_range(0, 1));
            rx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(120, 127)) : int'($urandom_range(0, 119));
            ry = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 99));
            if ($urandom_range(0, 3) == 0) rx = int'($urandom_range(0, 3));
            req(rx, ry, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 1)), -1, 0);
        end
        rand_rdy = 1'b0;

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
